alu_acc: RTL and testbench



---
 rtl/alu_pkg.sv | 41 ++++
 rtl/alu_acc_mul.sv | 77 +++++++
 rtl/alu_acc.sv | 187 ++++++++++++++++++
 tb/tb_alu_acc.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the registered accumulator ALU (alu_acc).
// Contents:
//   opcode_e        4-bit opcode encoding, OP_MOVB (0) .. OP_MUL (15)
//   state_e         control FSM states: ST_IDLE accepts ops, ST_MUL runs the multiplier
//   op_writes_carry 1 when an opcode updates the sticky carry flag
package alu_pkg;

    typedef enum logic [3:0] {
        OP_MOVB  = 4'd0,
        OP_MOVAB = 4'd1,
        OP_ADD   = 4'd2,
        OP_SUB   = 4'd3,
        OP_AND   = 4'd4,
        OP_INCB  = 4'd5,
        OP_DECB  = 4'd6,
        OP_XOR   = 4'd7,
        OP_NOP   = 4'd8,
        OP_CLR   = 4'd9,
        OP_OR    = 4'd10,
        OP_SHL   = 4'd11,
        OP_SHR   = 4'd12,
        OP_ADC   = 4'd13,
        OP_SBC   = 4'd14,
        OP_MUL   = 4'd15
    } opcode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_e;

    // Arithmetic and shift ops own the carry/borrow flag; logic and move ops leave it alone.
    function automatic logic op_writes_carry(input opcode_e op);
        case (op)
            OP_ADD, OP_SUB, OP_INCB, OP_DECB,
            OP_SHL, OP_SHR, OP_ADC, OP_SBC, OP_MUL: op_writes_carry = 1'b1;
            default:                                 op_writes_carry = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_acc_mul.sv
// Iterative unsigned shift-add multiplier for alu_acc. It is only built when the
// ALU_ACC_MUL_EN macro is defined.
// One multiplier bit is consumed per clock. A start pulse loads the operands.
// done is high during the WIDTH-th busy cycle, and product then already includes
// that last partial sum, so the parent can capture it on the same edge.
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   start             load a (multiplicand) and b (multiplier), begin
//   a, b   [WIDTH]    operands
//   done              final step in progress; product valid this cycle
//   product [2*WIDTH] full-width product
module alu_acc_mul #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH);

    logic               busy_q, busy_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] step_sum;

    always_comb begin
        busy_d   = busy_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        prod_d   = prod_q;
        mplier_d = mplier_q;

        step_sum = prod_q + (mplier_q[0] ? mcand_q : '0);
        done     = busy_q && (cnt_q == CW'(WIDTH - 1));
        product  = step_sum;

        if (start) begin
            busy_d   = 1'b1;
            cnt_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
            prod_d   = '0;
        end else if (busy_q) begin
            prod_d   = step_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
            if (done) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            mcand_q  <= '0;
            prod_q   <= '0;
            mplier_q <= '0;
        end else begin
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            prod_q   <= prod_d;
            mplier_q <= mplier_d;
        end
    end

endmodule

// File: rtl/alu_acc.sv
// Registered accumulator ALU with a valid/ready handshake on both sides and a
// one-entry output buffer.
// Optional feature: define ALU_ACC_MUL_EN to make opcode 15 an iterative multiply
// (acc*b, WIDTH busy cycles). Without the macro, opcode 15 is a nop.
//
// Handshake: an op transfers on a clock edge where in_valid && in_ready. A result
// transfers on an edge where out_valid && out_ready. While out_valid is high and
// out_ready is low, ans and the flags hold and in_ready stays low. A result can be
// consumed and the next op accepted on the same edge.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready     producer handshake for inst/b
//   inst [4], b [WIDTH]   opcode and B operand (A is the internal accumulator)
//   out_valid/out_ready   consumer handshake for ans/zero/carry
//   ans [WIDTH+1]         held result; bit WIDTH is carry (add) or borrow (sub)
//   acc [WIDTH]           current accumulator
//   zero, carry           zero of held result, sticky carry flag
module alu_acc
    import alu_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       inst,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   ans,
    output logic [WIDTH-1:0] acc,
    output logic             zero,
    output logic             carry
);

    localparam logic [WIDTH:0] ONE_X = {{WIDTH{1'b0}}, 1'b1};

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH:0]   ans_q, ans_d;
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;
    logic             out_valid_q, out_valid_d;

    opcode_e          op;
    logic [WIDTH:0]   res;
    logic             upd;
    logic             idle;
    logic             accept;

    assign op       = opcode_e'(inst);
    assign in_ready = idle && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

`ifdef ALU_ACC_MUL_EN
    state_e               state_q, state_d;
    logic                 mul_start;
    logic                 mul_done;
    logic [2*WIDTH-1:0]   mul_product;

    assign idle      = (state_q == ST_IDLE);
    assign mul_start = accept && (op == OP_MUL);

    alu_acc_mul #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .a       (acc_q),
        .b       (b),
        .done    (mul_done),
        .product (mul_product)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (mul_start) state_d = ST_MUL;
            ST_MUL:  if (mul_done)  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end
`else
    assign idle = 1'b1;
`endif

    // Single-cycle result. Bit WIDTH is the carry for adds and shl, the borrow
    // for subtracts (two's-complement subtraction at WIDTH+1 bits leaves the
    // borrow there directly), and the shifted-out lsb for shr.
    always_comb begin
        res = '0;
        upd = 1'b1;
        case (op)
            OP_MOVB:  res = {1'b0, b};
            OP_MOVAB: res = {1'b0, acc_q};
            OP_ADD:   res = {1'b0, acc_q} + {1'b0, b};
            OP_SUB:   res = {1'b0, acc_q} - {1'b0, b};
            OP_AND:   res = {1'b0, acc_q & b};
            OP_INCB:  res = {1'b0, b} + ONE_X;
            OP_DECB:  res = {1'b0, b} - ONE_X;
            OP_XOR:   res = {1'b0, acc_q ^ b};
            OP_NOP:   upd = 1'b0;
            OP_CLR:   res = '0;
            OP_OR:    res = {1'b0, acc_q | b};
            OP_SHL:   res = {acc_q, 1'b0};
            OP_SHR:   res = {acc_q[0], 1'b0, acc_q[WIDTH-1:1]};
            OP_ADC:   res = {1'b0, acc_q} + {1'b0, b} + {{WIDTH{1'b0}}, carry_q};
            OP_SBC:   res = {1'b0, acc_q} - {1'b0, b} - {{WIDTH{1'b0}}, carry_q};
            // Multiply goes through the iterative path; without it this is a nop.
            OP_MUL:   upd = 1'b0;
            default:  upd = 1'b0;
        endcase
    end

    always_comb begin
        acc_d       = acc_q;
        ans_d       = ans_q;
        carry_d     = carry_q;
        zero_d      = zero_q;
        out_valid_d = out_valid_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (accept) begin
`ifdef ALU_ACC_MUL_EN
            // A multiply produces its result only when the iteration ends.
            if (op != OP_MUL) begin
                out_valid_d = 1'b1;
            end
`else
            out_valid_d = 1'b1;
`endif
            if (upd) begin
                ans_d  = res;
                acc_d  = res[WIDTH-1:0];
                zero_d = (res[WIDTH-1:0] == '0);
                if (op_writes_carry(op)) begin
                    carry_d = res[WIDTH];
                end
            end
        end

`ifdef ALU_ACC_MUL_EN
        if (state_q == ST_MUL && mul_done) begin
            ans_d       = {1'b0, mul_product[WIDTH-1:0]};
            acc_d       = mul_product[WIDTH-1:0];
            zero_d      = (mul_product[WIDTH-1:0] == '0);
            carry_d     = |mul_product[2*WIDTH-1:WIDTH];
            out_valid_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q       <= ACC_INIT;
            ans_q       <= '0;
            carry_q     <= 1'b0;
            zero_q      <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            ans_q       <= ans_d;
            carry_q     <= carry_d;
            zero_q      <= zero_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign ans       = ans_q;
    assign acc       = acc_q;
    assign zero      = zero_q;
    assign carry     = carry_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_alu_acc.sv
// Directed bench for alu_acc (WIDTH=8, ACC_INIT=0): a vector table applied
// back-to-back, then hand-written sequences for backpressure, opcode 15 and reset.
module tb_alu_acc;
    import alu_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   inst;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W:0]   ans;
    logic [W-1:0] acc;
    logic         zero;
    logic         carry;

    int tests = 0;
    int fails = 0;

    alu_acc #(.WIDTH(W), .ACC_INIT(8'h00)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .inst      (inst),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ans       (ans),
        .acc       (acc),
        .zero      (zero),
        .carry     (carry)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [3:0]   inst;
        logic [W-1:0] b;
        logic [W:0]   ans;
        logic [W-1:0] acc;
        logic         c;
        logic         z;
    } vec_t;

    localparam int NV = 23;
    vec_t vecs[NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_result(input string name, input logic [W:0] e_ans, input logic [W-1:0] e_acc,
                                input logic e_c, input logic e_z);
        check({name, " ans"},   32'(ans),   32'(e_ans));
        check({name, " acc"},   32'(acc),   32'(e_acc));
        check({name, " carry"}, 32'(carry), 32'(e_c));
        check({name, " zero"},  32'(zero),  32'(e_z));
    endtask

    // Present one op for exactly one edge; sample 1 ns after that edge.
    task automatic drive_op(input logic [3:0] i, input logic [W-1:0] bv);
        in_valid = 1'b1;
        inst     = i;
        b        = bv;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        logic ready_seen;

        // Running sequence from reset: acc=0, carry=0.
        vecs[0]  = '{OP_MOVB,  8'h5A, 9'h05A, 8'h5A, 1'b0, 1'b0};
        vecs[1]  = '{OP_ADD,   8'hB0, 9'h10A, 8'h0A, 1'b1, 1'b0};
        vecs[2]  = '{OP_MOVB,  8'h10, 9'h010, 8'h10, 1'b1, 1'b0};
        vecs[3]  = '{OP_SUB,   8'h20, 9'h1F0, 8'hF0, 1'b1, 1'b0};
        vecs[4]  = '{OP_SBC,   8'h00, 9'h0EF, 8'hEF, 1'b0, 1'b0};
        vecs[5]  = '{OP_INCB,  8'hFF, 9'h100, 8'h00, 1'b1, 1'b1};
        vecs[6]  = '{OP_NOP,   8'hAA, 9'h100, 8'h00, 1'b1, 1'b1};
        vecs[7]  = '{OP_DECB,  8'h00, 9'h1FF, 8'hFF, 1'b1, 1'b0};
        vecs[8]  = '{OP_AND,   8'h0F, 9'h00F, 8'h0F, 1'b1, 1'b0};
        vecs[9]  = '{OP_XOR,   8'hFF, 9'h0F0, 8'hF0, 1'b1, 1'b0};
        vecs[10] = '{OP_OR,    8'h0C, 9'h0FC, 8'hFC, 1'b1, 1'b0};
        vecs[11] = '{OP_SHL,   8'h00, 9'h1F8, 8'hF8, 1'b1, 1'b0};
        vecs[12] = '{OP_SHR,   8'h00, 9'h07C, 8'h7C, 1'b0, 1'b0};
        vecs[13] = '{OP_ADC,   8'h84, 9'h100, 8'h00, 1'b1, 1'b1};
        vecs[14] = '{OP_ADC,   8'h01, 9'h002, 8'h02, 1'b0, 1'b0};
        vecs[15] = '{OP_MOVAB, 8'h77, 9'h002, 8'h02, 1'b0, 1'b0};
        vecs[16] = '{OP_CLR,   8'h55, 9'h000, 8'h00, 1'b0, 1'b1};
        vecs[17] = '{OP_MOVB,  8'h81, 9'h081, 8'h81, 1'b0, 1'b0};
        vecs[18] = '{OP_SHR,   8'h00, 9'h140, 8'h40, 1'b1, 1'b0};
        vecs[19] = '{OP_SUB,   8'h40, 9'h000, 8'h00, 1'b0, 1'b1};
        vecs[20] = '{OP_SBC,   8'h01, 9'h1FF, 8'hFF, 1'b1, 1'b0};
        vecs[21] = '{OP_SBC,   8'h00, 9'h0FE, 8'hFE, 1'b0, 1'b0};
        vecs[22] = '{OP_INCB,  8'h41, 9'h042, 8'h42, 1'b0, 1'b0};

        // Clock/reset
        reset     = 1'b1;
        in_valid  = 1'b0;
        inst      = 4'd0;
        b         = '0;
        out_ready = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check_result("reset", 9'h000, 8'h00, 1'b0, 1'b1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset in_ready",  32'(in_ready),  32'd1);

        // Table, back-to-back with out_ready=1: in_ready must stay high every cycle.
        for (int i = 0; i < NV; i++) begin
            check($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'd1);
            drive_op(vecs[i].inst, vecs[i].b);
            check($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'd1);
            check_result($sformatf("vec%0d", i), vecs[i].ans, vecs[i].acc, vecs[i].c, vecs[i].z);
        end

        // Idle with out_ready=1: result is consumed and out_valid drops.
        tick();
        check("drain out_valid", 32'(out_valid), 32'd0);
        check_result("drain hold", 9'h042, 8'h42, 1'b0, 1'b0);

        // Backpressure: result held, in_ready low for 5 cycles, then same-edge accept.
        out_ready = 1'b0;
        drive_op(OP_MOVB, 8'h33);
        check("bp first out_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b1;
        inst     = OP_ADD;
        b        = 8'h01;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp%0d in_ready", k), 32'(in_ready), 32'd0);
            tick();
            check($sformatf("bp%0d out_valid", k), 32'(out_valid), 32'd1);
            check($sformatf("bp%0d ans", k), 32'(ans), 32'h033);
            check($sformatf("bp%0d acc", k), 32'(acc), 32'h33);
        end
        out_ready = 1'b1;
        #1;
        check("bp release in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check("bp accept out_valid", 32'(out_valid), 32'd1);
        check_result("bp accept", 9'h034, 8'h34, 1'b0, 1'b0);
        tick();
        check("bp drain out_valid", 32'(out_valid), 32'd0);

`ifdef ALU_ACC_MUL_EN
        // 0x12 * 0x34 = 0x3A8: low byte 0xA8, nonzero high byte -> carry.
        drive_op(OP_MOVB, 8'h12);
        check("mul setup acc", 32'(acc), 32'h12);
        drive_op(OP_MUL, 8'h34);
        n = 1;
        ready_seen = 1'b0;
        while (!out_valid && n < 40) begin
            if (in_ready) ready_seen = 1'b1;
            tick();
            n++;
        end
        check("mul latency", 32'(n), 32'd9);
        check("mul in_ready low while busy", 32'(ready_seen), 32'd0);
        check_result("mul", 9'h0A8, 8'hA8, 1'b1, 1'b0);
        tick();

        // Reset part-way through a multiply aborts it.
        drive_op(OP_MUL, 8'h03);
        tick();
        tick();
        check("mul abort busy in_ready", 32'(in_ready), 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mul abort in_ready", 32'(in_ready), 32'd1);
        check("mul abort out_valid", 32'(out_valid), 32'd0);
        check("mul abort acc", 32'(acc), 32'h00);
        drive_op(OP_MOVB, 8'h21);
        check("post abort acc", 32'(acc), 32'h21);
        ready_seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (out_valid) ready_seen = 1'b1;
        end
        check("post abort no stale result", 32'(ready_seen), 32'd0);
`else
        // Opcode 15 without the multiplier: a nop that still pulses out_valid.
        drive_op(OP_MUL, 8'h34);
        check("op15 out_valid", 32'(out_valid), 32'd1);
        check_result("op15 nop", 9'h034, 8'h34, 1'b0, 1'b0);
        check("op15 in_ready", 32'(in_ready), 32'd1);
        tick();
        check("op15 drain out_valid", 32'(out_valid), 32'd0);
`endif

        // Reset mid-stream while an op is being offered.
        drive_op(OP_MOVB, 8'h77);
        drive_op(OP_ADD, 8'h90);
        check_result("pre-reset", 9'h107, 8'h07, 1'b1, 1'b0);
        in_valid = 1'b1;
        inst     = OP_ADD;
        b        = 8'h01;
        reset    = 1'b1;
        tick();
        reset    = 1'b0;
        in_valid = 1'b0;
        check("midreset out_valid", 32'(out_valid), 32'd0);
        check_result("midreset", 9'h000, 8'h00, 1'b0, 1'b1);
        check("midreset in_ready", 32'(in_ready), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
